// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: majority-samples RX_IN at mid-bit, checks
// start/parity/stop and deserializes an LSB-first byte onto P_DATA.
//
//   state  | meaning
//   IDLE   | line idle, waiting for a low level on RX_IN
//   START  | start bit, rejected as a glitch if it samples high
//   DATA   | payload bits, shifted in LSB first
//   PARITY | parity bit, compared against the latched parity type
//   STOP   | stop bit, byte published here if the frame is clean
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  input  logic [4:0]            edge_cnt,
  input  logic [3:0]            bit_cnt,
  output logic                  edge_cnt_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic                  s0, s1, s2;
  logic                  par_en_q, par_typ_q;

  logic [5:0] mid;
  logic [5:0] edge_w;
  logic       decide;
  logic       last_edge;
  logic       bit_val;
  logic       par_exp;

  assign mid       = {1'b0, Prescale[5:1]};
  assign edge_w    = {1'b0, edge_cnt};
  assign decide    = (edge_w == mid + 6'd2);
  assign last_edge = (edge_w == Prescale - 6'd1);
  assign bit_val   = (s0 & s1) | (s0 & s2) | (s1 & s2);
  // Odd parity expects the XNOR of the payload, i.e. XOR flipped by PAR_TYP.
  assign par_exp   = (^shift) ^ par_typ_q;

  assign edge_cnt_en = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      if (edge_w == mid - 6'd1) s0 <= RX_IN;
      if (edge_w == mid)        s1 <= RX_IN;
      if (edge_w == mid + 6'd1) s2 <= RX_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      shift       <= '0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      strt_glitch <= 1'b0;
      par_en_q    <= 1'b0;
      par_typ_q   <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state     <= START;
            par_err   <= 1'b0;
            stp_err   <= 1'b0;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end
        end
        START: begin
          if (decide && bit_val) begin
            strt_glitch <= 1'b1;
            state       <= IDLE;
          end else if (last_edge && bit_cnt == 4'd0) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decide) shift <= {bit_val, shift[DATA_WIDTH-1:1]};
          if (last_edge && bit_cnt == 4'(DATA_WIDTH))
            state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (decide) par_err <= (bit_val != par_exp);
          if (last_edge) state <= STOP;
        end
        STOP: begin
          // Leave mid-stop so a back-to-back start edge is not missed.
          if (decide) begin
            stp_err <= ~bit_val;
            if (bit_val && !par_err) begin
              P_DATA     <= shift;
              data_valid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
UART receive frame controller. It consumes edge_cnt/bit_cnt from the RX edge/bit counter and drives that counter's edge_cnt_en. It majority-samples RX_IN at mid-bit, checks the start, parity and stop bits, and deserializes the 8-bit payload (LSB first). A complete, error-free frame is presented on P_DATA with a one-cycle data_valid pulse to the downstream synchronizer.

Parameters:
DATA_WIDTH, 8, payload bits per frame; only 8 is supported because the bit counter wraps after bit index 10.

Ports:
CLK  in  1  receiver oversampling clock
RST  in  1  reset, asynchronous, active-low
RX_IN  in  1  serial line, idle high, already synchronized to CLK
PAR_EN  in  1  1 = parity bit present
PAR_TYP  in  1  0 = even parity, 1 = odd parity
Prescale  in  6  oversampling ratio; legal values 8, 16, 32
edge_cnt  in  5  edge count within the current bit, 0..Prescale-1
bit_cnt  in  4  bit index in frame: 0 = start, 1..8 = data, 9 = parity or stop, 10 = stop
edge_cnt_en  out  1  counter enable; counter clears while low
P_DATA  out  8  received byte
data_valid  out  1  one-cycle pulse when P_DATA is updated
par_err  out  1  parity mismatch in last frame
stp_err  out  1  stop bit sampled low in last frame
strt_glitch  out  1  one-cycle pulse when a false start is rejected

Behaviour:
- Reset (async, RST=0):
  - state = IDLE.
  - P_DATA = 0, data_valid = 0, par_err = 0, stp_err = 0, strt_glitch = 0.
  - Shift register and sample registers = 0.
  - Reset mid-frame aborts the frame with no outputs asserted.
- Derived values: mid = Prescale>>1. Samples are taken at edge_cnt = mid-1, mid and mid+1. The decision edge is edge_cnt = mid+2. For Prescale 8 this gives samples at 3, 4, 5 and the decision at 6.
- Sampling:
  - RX_IN is registered into s0/s1/s2 on the clock edges where edge_cnt equals each sample point.
  - bit_val = majority(s0, s1, s2), used only at the decision edge.
- edge_cnt_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE. It is a combinational decode of the state.
- Configuration: PAR_EN and PAR_TYP are latched on the IDLE->START transition. Changes mid-frame are ignored.
- FSM:
  - IDLE: when RX_IN==0, go to START. Clear par_err and stp_err on this transition. The counter is at 0 on the first START cycle.
  - START, at the decision edge: if bit_val==1, pulse strt_glitch and return to IDLE (counter clears). Otherwise stay in START.
  - START exit: when edge_cnt==Prescale-1 and bit_cnt==0, go to DATA.
  - DATA, at the decision edge: shift right, inserting bit_val at bit 7. This yields LSB-first assembly.
  - DATA exit: when edge_cnt==Prescale-1 and bit_cnt==8, go to PARITY if PAR_EN, else STOP.
  - PARITY, at the decision edge: expected = ^shift for even, ~^shift for odd. par_err <= (bit_val != expected).
  - PARITY exit: when edge_cnt==Prescale-1, go to STOP.
  - STOP, at the decision edge: stp_err <= ~bit_val. If bit_val==1 and par_err==0, then P_DATA <= shift and data_valid pulses. In all cases go to IDLE on the same edge.
  - Leaving at mid-stop permits resynchronization on a back-to-back start bit.
- Output timing: data_valid, strt_glitch, par_err and stp_err are registered and are high starting the cycle after the decision edge. data_valid and strt_glitch last exactly 1 cycle.
- Error retention:
  - par_err and stp_err hold until the next start detection.
  - Both may be set in the same frame.
  - P_DATA is unchanged on any error or glitch.
- Start detection while RX_IN is still low after a rejected glitch is legal: IDLE re-enters START on the next cycle.

Test Plan:
1. Prescale=8, PAR_EN=1, PAR_TYP=0; send 0xA5 (bits LSB first 1,0,1,0,0,1,0,1), parity 0, stop 1 -> data_valid pulses once, P_DATA=0xA5, par_err=0, stp_err=0.
2. Same frame with parity bit 1 -> par_err=1, no data_valid, P_DATA keeps its previous value; par_err clears on the next start.
3. Prescale=16, PAR_EN=0; send 0x3C with stop bit 0 -> stp_err=1, no data_valid, FSM back in IDLE after the stop decision edge.
4. Prescale=8; RX_IN low for 3 cycles then high -> strt_glitch one-cycle pulse, edge_cnt_en falls to 0, no data_valid.
5. Prescale=32, PAR_EN=1, PAR_TYP=1; back-to-back frames 0x00 then 0xFF, second start bit immediately after the stop bit -> two data_valid pulses, P_DATA 0x00 then 0xFF, no errors.
6. Assert RST during DATA bit 4 -> all outputs 0 immediately, edge_cnt_en=0; the next valid frame 0x5A is received correctly.
